addr_reg_bank: RTL
==================

// Module: addr_reg_bank
// PURPOSE
//  Parametrised bank of address registers that are loaded one nibble at a time from the
//  narrow data bus. Each register holds a full address and can post-increment or
//  post-decrement, with a registered wrap flag. The bank supersedes the fixed B/C pairs
//  of 4-bit registers that feed the 16-bit address bus in the slug core.
//  Sits between the DATA_W data bus (driven by microcode) and the ADDR_W address bus.
// PARAMETERS
//  DATA_W   4   width of the data bus and of each nibble
//  ADDR_W   16  width of each address register; must be a multiple of DATA_W
//  NREGS    2   number of address registers; must be >= 2
//  NIB      ADDR_W/DATA_W (derived, not overridable)   nibbles per register
// PORTS
//  clk        in   1                 rising-edge clock
//  rst        in   1                 asynchronous reset, active-low
//  ld         in   1                 load one nibble of register wr_sel
//  seq        in   1                 1: nibble index comes from the register's own pointer; 0: from nib_sel
//  wr_sel     in   $clog2(NREGS)     register targeted by ld/inc/dec/ptr_clr
//  nib_sel    in   $clog2(NIB)       explicit nibble index, used when seq=0
//  data_in    in   DATA_W            nibble to load
//  ptr_clr    in   1                 clear the nibble pointer of wr_sel
//  inc        in   1                 post-increment wr_sel by 1
//  dec        in   1                 post-decrement wr_sel by 1
//  rd_sel     in   $clog2(NREGS)     register driven onto addr_out
//  oe         in   1                 output enable for addr_out
//  addr_out   out  ADDR_W            oe ? reg[rd_sel] : 0 (combinational)
//  ptr        out  $clog2(NIB)       current nibble pointer of wr_sel (combinational)
//  wrap       out  1                 one-cycle registered pulse on increment/decrement wrap
// BEHAVIOUR
//  - Reset (rst=0, async): all registers=0, all pointers=0, wrap=0. addr_out=0 while oe=0.
//  - All state updates on posedge clk. Only register wr_sel is affected in a cycle.
//  - Nibble load:
//    - Index = seq ? ptr[wr_sel] : nib_sel.
//    - Nibble k occupies bits [k*DATA_W +: DATA_W]; nibble 0 is the LSB.
//    - The other nibbles are unchanged.
//    - Out-of-range nib_sel (>=NIB, non-power-of-2 NIB only): no load.
//  - Pointer update:
//    - Advances by 1 after each ld with seq=1 and wraps from NIB-1 to 0.
//    - Does not change on ld with seq=0, or on inc/dec.
//    - ptr_clr forces ptr[wr_sel]=0 and takes priority over the advance; any load in the
//      same cycle still uses the old pointer.
//  - Priority per cycle: ld > (inc xor dec).
//    - inc and dec together, without ld: no change.
//    - ld with inc/dec: the load wins and inc/dec is ignored.
//  - Arithmetic: modulo 2^ADDR_W.
//    - inc from all-ones gives 0 and wrap=1 the next cycle.
//    - dec from 0 gives all-ones and wrap=1 the next cycle.
//    - Otherwise wrap=0, so wrap is high for exactly one cycle per wrap event.
//  - Read: addr_out reflects the register state before the edge. A register written at
//    edge N shows its new value after edge N (no bypass). rd_sel==wr_sel is legal.
//  - Out-of-range wr_sel/rd_sel (non-power-of-2 NREGS):
//    - Write-side controls are ignored.
//    - addr_out=0.
//  - Reset mid-sequence: a partially loaded register and its pointer return to 0 at
//    once. The next seq load starts at nibble 0.
//  - Latency: load/inc/dec are visible on addr_out 1 cycle after the edge. wrap is
//    registered, so it is 1 cycle.
// TESTING
//  1. Reset with oe=1, rd_sel=0 -> addr_out=0x0000, ptr=0, wrap=0; reset asserted async mid-cycle clears at once.
//  2. seq=1, wr_sel=1, ld for 4 cycles with data F,E,E,B -> reg1=0xBEEF, ptr back to 0; reg0 still 0.
//  3. reg0=0xFFFF, inc one cycle -> reg0=0x0000, wrap=1 for exactly one cycle; dec from 0 -> 0xFFFF, wrap pulse.
//  4. seq=0, nib_sel=2, data=0xA, ld with inc in the same cycle on reg0=0x1234 -> 0x1A34 (no increment); inc+dec alone -> unchanged.
//  5. seq load of 2 nibbles, rst pulse, then 4 seq loads of 1,2,3,4 -> reg=0x4321 (pointer restarted).
//  6. ptr_clr with ld seq=1 at ptr=2, data=7 -> nibble 2 loaded with 7, ptr=0 afterwards.

Source files
------------

// File: rtl/addr_reg_bank.sv
// Bank of address registers loaded one nibble at a time from the data bus,
// with post-increment/decrement and a registered one-cycle wrap pulse.
module addr_reg_bank #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned NREGS  = 2
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst_n,
    input  logic                                         i_ld,
    input  logic                                         i_seq,
    input  logic [$clog2(NREGS)-1:0]                     i_wr_sel,
    input  logic [((ADDR_W/DATA_W) > 1 ? $clog2(ADDR_W/DATA_W) : 1)-1:0] i_nib_sel,
    input  logic [DATA_W-1:0]                            i_data_in,
    input  logic                                         i_ptr_clr,
    input  logic                                         i_inc,
    input  logic                                         i_dec,
    input  logic [$clog2(NREGS)-1:0]                     i_rd_sel,
    input  logic                                         i_oe,
    output logic [ADDR_W-1:0]                            o_addr_out,
    output logic [((ADDR_W/DATA_W) > 1 ? $clog2(ADDR_W/DATA_W) : 1)-1:0] o_ptr,
    output logic                                         o_wrap
);

    localparam int unsigned NIB = ADDR_W / DATA_W;
    localparam int unsigned SW  = $clog2(NREGS);
    localparam int unsigned PW  = (NIB > 1) ? $clog2(NIB) : 1;

    logic [ADDR_W-1:0] r_regs [NREGS];
    logic [PW-1:0]     r_ptr  [NREGS];
    logic              r_wrap;

    logic              w_wr_valid;
    logic [ADDR_W-1:0] w_cur_reg;
    logic [PW-1:0]     w_cur_ptr;
    logic [ADDR_W-1:0] w_rd_reg;
    logic [PW-1:0]     w_idx;
    logic [ADDR_W-1:0] w_next_reg;
    logic [PW-1:0]     w_next_ptr;
    logic              w_wrap_evt;

    assign w_wr_valid = (32'(i_wr_sel) < NREGS);

    // Selector-matched muxes: an out-of-range select matches nothing and reads as 0.
    always_comb begin
        w_cur_reg = '0;
        w_cur_ptr = '0;
        w_rd_reg  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (i_wr_sel == SW'(i)) begin
                w_cur_reg = r_regs[i];
                w_cur_ptr = r_ptr[i];
            end
            if (i_rd_sel == SW'(i)) begin
                w_rd_reg = r_regs[i];
            end
        end
    end

    always_comb begin
        w_idx      = i_seq ? w_cur_ptr : i_nib_sel;
        w_next_reg = w_cur_reg;
        w_next_ptr = w_cur_ptr;
        w_wrap_evt = 1'b0;
        if (i_ld) begin
            // An index >= NIB matches no nibble, so the load is dropped.
            for (int k = 0; k < NIB; k++) begin
                if (w_idx == PW'(k)) begin
                    w_next_reg[k*DATA_W +: DATA_W] = i_data_in;
                end
            end
            if (i_seq) begin
                w_next_ptr = (w_cur_ptr == PW'(NIB - 1)) ? '0 : w_cur_ptr + PW'(1);
            end
        end else if (i_inc && !i_dec) begin
            w_next_reg = w_cur_reg + ADDR_W'(1);
            w_wrap_evt = &w_cur_reg;
        end else if (i_dec && !i_inc) begin
            w_next_reg = w_cur_reg - ADDR_W'(1);
            w_wrap_evt = ~|w_cur_reg;
        end
        if (i_ptr_clr) begin
            w_next_ptr = '0;
        end
        w_wrap_evt = w_wrap_evt & w_wr_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
                r_ptr[i]  <= '0;
            end
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_evt;
            for (int i = 0; i < NREGS; i++) begin
                if (i_wr_sel == SW'(i)) begin
                    r_regs[i] <= w_next_reg;
                    r_ptr[i]  <= w_next_ptr;
                end
            end
        end
    end

    assign o_addr_out = i_oe ? w_rd_reg : '0;
    assign o_ptr      = w_cur_ptr;
    assign o_wrap     = r_wrap;

endmodule
